// File: rtl/biu_pkg.sv
// Shared BIU definitions: bus-cycle states, address geometry and access-type encodings.
package biu_pkg;
    localparam int PHYS_AW   = 20;
    localparam int SEG_SHIFT = 4;

    localparam logic ACC_BYTE = 1'b0;
    localparam logic ACC_WORD = 1'b1;
    localparam logic ACC_RD   = 1'b0;
    localparam logic ACC_WR   = 1'b1;

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4} bus_state_t;

    typedef struct packed {
        logic        wr;
        logic        word;
        logic        split;
        logic [15:0] wdata;
    } biu_req_t;

    function automatic logic [15:0] dup_byte(input logic [7:0] b);
        return {b, b};
    endfunction
endpackage

// File: rtl/biu_phys_addr.sv
// Segment:offset to 20-bit physical address; the carry out of the top bit wraps like a real 8086.
module biu_phys_addr
    import biu_pkg::*;
(
    input  logic [15:0]        seg,
    input  logic [15:0]        off,
    output logic [PHYS_AW-1:0] phys
);
    assign phys = {seg, {SEG_SHIFT{1'b0}}} + {{(PHYS_AW-16){1'b0}}, off};
endmodule

// File: rtl/biu_bus_cycle_ctrl.sv
// 8086 BIU bus-cycle sequencer: T1-T2-T3-[TW]-T4 per access, odd word accesses split in two byte cycles.
module biu_bus_cycle_ctrl
    import biu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [15:0]        req_seg,
    input  logic [15:0]        req_off,
    input  logic               req_wr,
    input  logic               req_word,
    input  logic [15:0]        req_wdata,
    output logic               resp_valid,
    output logic [15:0]        resp_rdata,
    output logic               resp_err,
    output logic               ale,
    output logic [PHYS_AW-1:0] addr_out,
    output logic               bhe_n,
    output logic               rd_n,
    output logic               wr_n,
    output logic [15:0]        dout,
    output logic               dout_oe,
    input  logic [15:0]        din,
    input  logic               ready
);
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

    bus_state_t         state;
    biu_req_t           cur;
    logic               phase2;
    logic [7:0]         rd_lo;
    logic [15:0]        wcnt;
    logic [PHYS_AW-1:0] phys;
    logic               to_hit, go_t4, last;
    logic [15:0]        wr_lanes, rd_word;

    biu_phys_addr u_phys (.seg(req_seg), .off(req_off), .phys(phys));

    always_comb begin
        to_hit = (state == S_TW) && !ready && (TIMEOUT != 0) && (wcnt >= TO_LIM);
        go_t4  = ((state == S_T3) || (state == S_TW)) && (ready || to_hit);
        // Final bus cycle of the request: non-split, split phase 2, or any aborted cycle.
        last   = !cur.split || phase2 || to_hit;

        if (cur.split)
            wr_lanes = phase2 ? dup_byte(cur.wdata[15:8]) : dup_byte(cur.wdata[7:0]);
        else if (cur.word == ACC_WORD)
            wr_lanes = cur.wdata;
        else
            wr_lanes = dup_byte(cur.wdata[7:0]);

        if (cur.split)
            rd_word = {din[7:0], rd_lo};
        else if (cur.word == ACC_WORD)
            rd_word = din;
        else
            rd_word = {8'h00, addr_out[0] ? din[15:8] : din[7:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cur        <= '0;
            phase2     <= 1'b0;
            rd_lo      <= 8'h00;
            wcnt       <= 16'h0000;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 16'h0000;
            ale        <= 1'b0;
            addr_out   <= '0;
            bhe_n      <= 1'b1;
            rd_n       <= 1'b1;
            wr_n       <= 1'b1;
            dout       <= 16'h0000;
            dout_oe    <= 1'b0;
        end else begin
            ale        <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        cur       <= '{wr: req_wr, word: req_word,
                                       split: req_word & phys[0], wdata: req_wdata};
                        phase2    <= 1'b0;
                        addr_out  <= phys;
                        bhe_n     <= (req_word == ACC_WORD) ? 1'b0 : ~phys[0];
                        ale       <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= S_T1;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_T1: begin
                    if (cur.wr == ACC_WR) begin
                        wr_n    <= 1'b0;
                        dout_oe <= 1'b1;
                        dout    <= wr_lanes;
                    end else begin
                        rd_n <= 1'b0;
                    end
                    state <= S_T2;
                end
                S_T2: state <= S_T3;
                S_T3, S_TW: begin
                    if (go_t4) begin
                        rd_n       <= 1'b1;
                        wr_n       <= 1'b1;
                        resp_valid <= last;
                        resp_err   <= to_hit;
                        if (cur.wr == ACC_RD && !to_hit) begin
                            if (!last) rd_lo      <= din[15:8];
                            else       resp_rdata <= rd_word;
                        end
                        state <= S_T4;
                    end else begin
                        if (wcnt != 16'hFFFF) wcnt <= wcnt + 16'd1;
                        state <= S_TW;
                    end
                end
                S_T4: begin
                    wcnt    <= 16'h0000;
                    dout_oe <= 1'b0;
                    if (resp_valid) begin
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        // Second half of a split word: high byte at the next (even) address.
                        phase2   <= 1'b1;
                        addr_out <= addr_out + 1'b1;
                        bhe_n    <= 1'b1;
                        ale      <= 1'b1;
                        state    <= S_T1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_biu_bus_cycle_ctrl.sv
// Bench for biu_bus_cycle_ctrl: byte-addressed memory responder plus directed and random transactions.
module tb_biu_bus_cycle_ctrl;
    localparam int TO = 4;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        req_valid = 1'b0, req_wr = 1'b0, req_word = 1'b0;
    logic [15:0] req_seg = '0, req_off = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, ale, bhe_n, rd_n, wr_n, dout_oe;
    logic [15:0] resp_rdata, dout;
    logic [19:0] addr_out;
    logic [15:0] din = '0;
    logic        ready = 1'b1;

    int total = 0, bad = 0;

    biu_bus_cycle_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_seg(req_seg), .req_off(req_off), .req_wr(req_wr), .req_word(req_word),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .ale(ale), .addr_out(addr_out), .bhe_n(bhe_n),
        .rd_n(rd_n), .wr_n(wr_n), .dout(dout), .dout_oe(dout_oe), .din(din), .ready(ready)
    );

    always #5 clk = ~clk;

    // Byte-addressed memory; unwritten bytes come from a fixed hash.
    logic [7:0]  mem [int];
    int          wt [2];
    int          ale_cnt = 0, ale_base = 0, bj = 0, cur_w = 0, cur_idx = -1;
    bit          wdone = 1'b0;
    logic [19:0] tr_addr [2];
    logic        tr_bhe [2];
    logic [15:0] tr_dout [2];

    function automatic logic [7:0] rdmem(input int a);
        logic [7:0] h;
        if (mem.exists(a)) return mem[a];
        h = 8'(a * 29 + (a >>> 9));
        return h ^ 8'h5A;
    endfunction

    function automatic int pa(input int seg, input int off);
        return (seg * 16 + off) % 1048576;
    endfunction

    always @(negedge clk) begin
        int a;
        a = {12'h0, addr_out};
        if (ale) begin
            bj = 0; ale_cnt++; wdone = 1'b0;
            cur_idx = ale_cnt - ale_base - 1;
            cur_w = (cur_idx >= 0 && cur_idx < 2) ? wt[cur_idx] : 0;
            if (cur_idx >= 0 && cur_idx < 2) begin
                tr_addr[cur_idx] = addr_out;
                tr_bhe[cur_idx]  = bhe_n;
            end
        end else begin
            bj++;
        end
        if (!wr_n && !wdone) begin
            wdone = 1'b1;
            if (!addr_out[0]) mem[a & ~1] = dout[7:0];
            if (!bhe_n)       mem[a | 1]  = dout[15:8];
            if (cur_idx >= 0 && cur_idx < 2) tr_dout[cur_idx] = dout;
        end
        ready = (bj >= 2 + cur_w);
        din   = {rdmem(a | 1), rdmem(a & ~1)};
    end

    task automatic run_req(input logic [15:0] seg, off, input logic wr, word,
                           input logic [15:0] wd, input int w1, w2, input bit hold,
                           output int lat, output logic [15:0] rdata, output logic err,
                           output int nale, output int wlow, output int rlow, output logic t4_idle);
        lat = -1; rdata = '0; err = 1'b0; nale = 0; wlow = 0; rlow = 0; t4_idle = 1'b0;
        for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
        if (!req_ready) return;
        wt[0] = w1; wt[1] = w2; ale_base = ale_cnt;
        req_seg = seg; req_off = off; req_wr = wr; req_word = word; req_wdata = wd;
        req_valid = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (i == 1) begin
                if (hold) begin
                    req_seg = ~seg; req_off = off ^ 16'h00F0; req_wr = ~wr; req_word = ~word;
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (!wr_n) wlow++;
            if (!rd_n) rlow++;
            if (resp_valid) begin
                lat = i; rdata = resp_rdata; err = resp_err; t4_idle = rd_n & wr_n;
                break;
            end
        end
        req_valid = 1'b0;
        nale = ale_cnt - ale_base;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({ale, rd_n, wr_n, bhe_n, req_ready, dout_oe, resp_valid, resp_err} !== 8'b01110000) begin
            bad++; $display("FAIL reset_ctrl: got %b want 01110000",
                {ale, rd_n, wr_n, bhe_n, req_ready, dout_oe, resp_valid, resp_err});
        end
        total++;
        if (addr_out !== 20'h0 || dout !== 16'h0 || resp_rdata !== 16'h0) begin
            bad++; $display("FAIL reset_data: got addr=%h dout=%h rdata=%h want 0", addr_out, dout, resp_rdata);
        end
        rst_n = 1'b1;
        #1 total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_early: got %b want 0", req_ready); end
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_rise: got %b want 1", req_ready); end
    endtask

    task automatic test_byte_read();
        int lat, na, wl, rl; logic [15:0] rd; logic er, t4;
        mem.delete(); mem['h12345] = 8'hAB; mem['h12344] = 8'h00;
        run_req(16'h1234, 16'h0005, 1'b0, 1'b0, 16'h0, 0, 0, 1'b0, lat, rd, er, na, wl, rl, t4);
        total++; if (lat !== 4) begin bad++; $display("FAIL byte_rd_lat: got %0d want 4", lat); end
        total++; if (rd !== 16'h00AB) begin bad++; $display("FAIL byte_rd_data: got %h want 00ab", rd); end
        total++; if (tr_addr[0] !== 20'h12345 || tr_bhe[0] !== 1'b0 || na !== 1) begin
            bad++; $display("FAIL byte_rd_bus: got addr=%h bhe=%b nale=%0d want 12345 0 1", tr_addr[0], tr_bhe[0], na);
        end
        total++; if (er !== 1'b0 || rl !== 2) begin bad++; $display("FAIL byte_rd_strobe: got err=%b rdlow=%0d want 0 2", er, rl); end
    endtask

    task automatic test_word_write_waits();
        int lat, na, wl, rl; logic [15:0] rd; logic er, t4;
        mem.delete();
        run_req(16'hF000, 16'h0010, 1'b1, 1'b1, 16'hBEEF, 2, 0, 1'b0, lat, rd, er, na, wl, rl, t4);
        total++; if (lat !== 6) begin bad++; $display("FAIL wr_lat: got %0d want 6", lat); end
        total++; if (wl !== 4 || t4 !== 1'b1) begin bad++; $display("FAIL wr_strobe: got wrlow=%0d t4idle=%b want 4 1", wl, t4); end
        total++; if (tr_addr[0] !== 20'hF0010 || tr_bhe[0] !== 1'b0 || tr_dout[0] !== 16'hBEEF) begin
            bad++; $display("FAIL wr_bus: got addr=%h bhe=%b dout=%h want f0010 0 beef", tr_addr[0], tr_bhe[0], tr_dout[0]);
        end
        total++; if (mem.num() !== 2 || rdmem('hF0010) !== 8'hEF || rdmem('hF0011) !== 8'hBE) begin
            bad++; $display("FAIL wr_mem: got n=%0d lo=%h hi=%h want 2 ef be", mem.num(), rdmem('hF0010), rdmem('hF0011));
        end
    endtask

    task automatic test_split_read();
        int lat, na, wl, rl; logic [15:0] rd; logic er, t4;
        mem.delete(); mem[0] = 8'h00; mem[1] = 8'h34; mem[2] = 8'h12; mem[3] = 8'h00;
        run_req(16'h0000, 16'h0001, 1'b0, 1'b1, 16'h0, 0, 0, 1'b0, lat, rd, er, na, wl, rl, t4);
        total++; if (lat !== 8 || na !== 2) begin bad++; $display("FAIL split_rd_lat: got lat=%0d nale=%0d want 8 2", lat, na); end
        total++; if (rd !== 16'h1234) begin bad++; $display("FAIL split_rd_data: got %h want 1234", rd); end
        total++; if (tr_addr[0] !== 20'h1 || tr_bhe[0] !== 1'b0 || tr_addr[1] !== 20'h2 || tr_bhe[1] !== 1'b1) begin
            bad++; $display("FAIL split_rd_bus: got %h/%b %h/%b want 00001/0 00002/1", tr_addr[0], tr_bhe[0], tr_addr[1], tr_bhe[1]);
        end
    endtask

    task automatic test_split_write();
        int lat, na, wl, rl; logic [15:0] rd; logic er, t4;
        mem.delete();
        run_req(16'h0100, 16'h0003, 1'b1, 1'b1, 16'hA55A, 1, 0, 1'b0, lat, rd, er, na, wl, rl, t4);
        total++; if (lat !== 9) begin bad++; $display("FAIL split_wr_lat: got %0d want 9", lat); end
        total++; if (tr_dout[0] !== 16'h5A5A || tr_dout[1] !== 16'hA5A5) begin
            bad++; $display("FAIL split_wr_lanes: got %h %h want 5a5a a5a5", tr_dout[0], tr_dout[1]);
        end
        total++; if (mem.num() !== 2 || rdmem('h1003) !== 8'h5A || rdmem('h1004) !== 8'hA5) begin
            bad++; $display("FAIL split_wr_mem: got n=%0d %h %h want 2 5a a5", mem.num(), rdmem('h1003), rdmem('h1004));
        end
    endtask

    task automatic test_wrap();
        int lat, na, wl, rl; logic [15:0] rd; logic er, t4;
        run_req(16'hFFFF, 16'h0010, 1'b0, 1'b0, 16'h0, 0, 0, 1'b0, lat, rd, er, na, wl, rl, t4);
        total++; if (tr_addr[0] !== 20'h00000) begin bad++; $display("FAIL wrap_addr: got %h want 00000", tr_addr[0]); end
        mem.delete(); mem['hFFFFF] = 8'hC3; mem[0] = 8'h5A;
        run_req(16'hFFFF, 16'h000F, 1'b0, 1'b1, 16'h0, 0, 0, 1'b0, lat, rd, er, na, wl, rl, t4);
        total++; if (tr_addr[0] !== 20'hFFFFF || tr_addr[1] !== 20'h00000) begin
            bad++; $display("FAIL wrap_split_addr: got %h %h want fffff 00000", tr_addr[0], tr_addr[1]);
        end
        total++; if (rd !== 16'h5AC3) begin bad++; $display("FAIL wrap_split_data: got %h want 5ac3", rd); end
    endtask

    task automatic test_timeout();
        int lat, na, wl, rl; logic [15:0] rd; logic er, t4;
        run_req(16'h2000, 16'h0000, 1'b0, 1'b0, 16'h0, 100, 0, 1'b0, lat, rd, er, na, wl, rl, t4);
        total++; if (lat !== 4 + TO || er !== 1'b1) begin bad++; $display("FAIL to_resp: got lat=%0d err=%b want %0d 1", lat, er, 4 + TO); end
        total++; if (rl !== 2 + TO || t4 !== 1'b1) begin bad++; $display("FAIL to_strobe: got rdlow=%0d t4idle=%b want %0d 1", rl, t4, 2 + TO); end
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL to_idle: got ready=%b rv=%b want 1 0", req_ready, resp_valid);
        end
        run_req(16'h0000, 16'h0003, 1'b0, 1'b1, 16'h0, 100, 0, 1'b0, lat, rd, er, na, wl, rl, t4);
        total++; if (na !== 1 || er !== 1'b1 || lat !== 4 + TO) begin
            bad++; $display("FAIL to_split: got nale=%0d err=%b lat=%0d want 1 1 %0d", na, er, lat, 4 + TO);
        end
        run_req(16'h0000, 16'h0040, 1'b0, 1'b0, 16'h0, TO, 0, 1'b0, lat, rd, er, na, wl, rl, t4);
        total++; if (er !== 1'b0 || lat !== 4 + TO) begin bad++; $display("FAIL to_edge: got err=%b lat=%0d want 0 %0d", er, lat, 4 + TO); end
    endtask

    task automatic test_back_to_back();
        int lat, na, wl, rl; logic [15:0] rd; logic er, t4;
        logic [15:0] exp_rd;
        exp_rd = {8'h00, rdmem('h402)};
        run_req(16'h0040, 16'h0002, 1'b0, 1'b0, 16'h0, 1, 0, 1'b1, lat, rd, er, na, wl, rl, t4);
        total++; if (na !== 1 || rd !== exp_rd || lat !== 5) begin
            bad++; $display("FAIL b2b_first: got nale=%0d rd=%h lat=%0d want 1 %h 5", na, rd, lat, exp_rd);
        end
        run_req(16'h0300, 16'h0007, 1'b1, 1'b0, 16'h0077, 0, 0, 1'b0, lat, rd, er, na, wl, rl, t4);
        total++; if (na !== 1 || tr_addr[0] !== 20'h03007 || lat !== 4 || rdmem('h3007) !== 8'h77) begin
            bad++; $display("FAIL b2b_second: got nale=%0d addr=%h lat=%0d mem=%h want 1 03007 4 77", na, tr_addr[0], lat, rdmem('h3007));
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
        req_seg = 16'h0500; req_off = 16'h0000; req_wr = 1'b0; req_word = 1'b0; req_valid = 1'b1;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 total++;
        if ({ale, rd_n, wr_n, bhe_n, req_ready, dout_oe, resp_valid} !== 7'b0111000 || addr_out !== 20'h0) begin
            bad++; $display("FAIL midrst_vals: got %b addr=%h want 0111000 00000",
                {ale, rd_n, wr_n, bhe_n, req_ready, dout_oe, resp_valid}, addr_out);
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
        total++; if (seen !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL midrst_drop: got resp_seen=%b ready=%b want 0 1", seen, req_ready);
        end
    endtask

    task automatic test_random();
        int lat, na, wl, rl; logic [15:0] rd; logic er, t4;
        int p, w1, w2, elat, ena; bit split, e1, eerr;
        logic [15:0] seg, off, wd, erd; logic wr, word;
        for (int it = 0; it < 40; it++) begin
            seg = 16'($urandom_range(0, 65535)); off = 16'($urandom_range(0, 65535));
            wr = 1'($urandom_range(0, 1)); word = 1'($urandom_range(0, 1)); wd = 16'($urandom);
            w1 = $urandom_range(0, 5); w2 = $urandom_range(0, 5);
            p = pa(int'(seg), int'(off));
            split = word && (p % 2 == 1);
            e1 = w1 > TO;
            eerr = e1 || (split && w2 > TO);
            elat = 4 + (w1 > TO ? TO : w1) + ((split && !e1) ? 4 + (w2 > TO ? TO : w2) : 0);
            ena = (split && !e1) ? 2 : 1;
            erd = word ? {rdmem((p + 1) % 1048576), rdmem(p)} : {8'h00, rdmem(p)};
            run_req(seg, off, wr, word, wd, w1, w2, 1'b0, lat, rd, er, na, wl, rl, t4);
            total++; if (lat !== elat || er !== eerr || na !== ena) begin
                bad++; $display("FAIL rnd_timing[%0d]: got lat=%0d err=%b nale=%0d want %0d %b %0d", it, lat, er, na, elat, eerr, ena);
            end
            if (!wr && !eerr) begin
                total++; if (rd !== erd) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", it, rd, erd); end
            end
            if (wr && !eerr) begin
                total++;
                if (rdmem(p) !== wd[7:0] || (word && rdmem((p + 1) % 1048576) !== wd[15:8])) begin
                    bad++; $display("FAIL rnd_wmem[%0d]: got %h%h want %h", it, rdmem((p + 1) % 1048576), rdmem(p), wd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_byte_read();
        test_word_write_waits();
        test_split_read();
        test_split_write();
        test_wrap();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
